// File: rtl/timer_control.sv
// Countdown-timer control core: start/pause/timeout FSM, one-second tick
// prescaler and 7-segment digit-scan selector.
module timer_control #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_DIV   = 65536,
  parameter int NUM_DIGITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        tim_zero,
  output logic        start_o,
  output logic        timeout,
  output logic        sec1,
  output logic [31:0] sec1_counter,
  output logic [1:0]  oe_digit
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_start_q;
  logic                r_start_o;
  logic                r_timeout;
  logic [31:0]         r_sec_cnt;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [1:0]          r_oe_digit;

  logic                w_start_edge;
  logic                w_sec_wrap;
  logic [31:0]         w_sec_next;
  logic                w_scan_wrap;

  assign w_start_edge = start_i & ~r_start_q;
  assign w_sec_wrap   = (r_sec_cnt == 32'(CLK_HZ - 1));
  assign w_sec_next   = w_sec_wrap ? 32'd0 : r_sec_cnt + 32'd1;
  assign w_scan_wrap  = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  // The tick counter follows the state it is in during the cycle, so the edge
  // that leaves RUN still advances it and PAUSE freezes the advanced value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_start_o <= 1'b0;
      r_timeout <= 1'b0;
      r_sec_cnt <= 32'd0;
    end else begin
      r_start_q <= start_i;
      case (r_state)
        S_IDLE: begin
          r_sec_cnt <= 32'd0;
          if (w_start_edge) begin
            r_state   <= S_RUN;
            r_start_o <= 1'b1;
          end
        end
        S_RUN: begin
          r_sec_cnt <= w_sec_next;
          if (tim_zero) begin
            r_state   <= S_TIMEOUT;
            r_start_o <= 1'b0;
            r_timeout <= 1'b1;
          end else if (w_start_edge) begin
            r_state   <= S_PAUSE;
            r_start_o <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (w_start_edge) begin
            r_state   <= S_RUN;
            r_start_o <= 1'b1;
          end
        end
        S_TIMEOUT: begin
          if (w_start_edge) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b0;
            r_sec_cnt <= 32'd0;
          end else begin
            r_sec_cnt <= w_sec_next;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_start_o <= 1'b0;
          r_timeout <= 1'b0;
          r_sec_cnt <= 32'd0;
        end
      endcase
    end
  end

  // Digit scan runs regardless of FSM state so the display never freezes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_oe_digit <= 2'd0;
    end else begin
      if (w_scan_wrap) begin
        r_scan_cnt <= '0;
        if (r_oe_digit == 2'(NUM_DIGITS - 1))
          r_oe_digit <= 2'd0;
        else
          r_oe_digit <= r_oe_digit + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
    end
  end

  assign start_o      = r_start_o;
  assign timeout      = r_timeout;
  assign sec1         = r_start_o & w_sec_wrap;
  assign sec1_counter = r_sec_cnt;
  assign oe_digit     = r_oe_digit;

endmodule

// File: tb/tb_timer_control.sv
// Directed bench for timer_control with CLK_HZ=10, SCAN_DIV=4, NUM_DIGITS=3.
module tb_timer_control;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic        tim_zero;
  logic        start_o;
  logic        timeout;
  logic        sec1;
  logic [31:0] sec1_counter;
  logic [1:0]  oe_digit;

  int checks;
  int errors;

  timer_control #(
    .CLK_HZ    (10),
    .SCAN_DIV  (4),
    .NUM_DIGITS(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .tim_zero    (tim_zero),
    .start_o     (start_o),
    .timeout     (timeout),
    .sec1        (sec1),
    .sec1_counter(sec1_counter),
    .oe_digit    (oe_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    start_i  = 1'b0;
    tim_zero = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start_i  = 1'b1;
    tim_zero = 1'b1;
    tick();
    tick();
    checks++;
    if (start_o !== 1'b0) begin errors++; $display("FAIL reset_start_o got %b exp 0", start_o); end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    checks++;
    if (sec1 !== 1'b0) begin errors++; $display("FAIL reset_sec1 got %b exp 0", sec1); end
    checks++;
    if (sec1_counter !== 32'd0) begin errors++; $display("FAIL reset_counter got %0d exp 0", sec1_counter); end
    checks++;
    if (oe_digit !== 2'd0) begin errors++; $display("FAIL reset_oe_digit got %0d exp 0", oe_digit); end
    // start_i high at release counts as an edge on the first clock
    tim_zero = 1'b0;
    reset    = 1'b0;
    tick();
    checks++;
    if (start_o !== 1'b1) begin errors++; $display("FAIL release_edge_start_o got %b exp 1", start_o); end
    start_i = 1'b0;
  endtask

  task automatic test_run_ticks();
    int n_sec;
    do_reset();
    pulse_start();
    n_sec = 0;
    for (int c = 1; c <= 30; c++) begin
      checks++;
      if (start_o !== 1'b1) begin errors++; $display("FAIL run_start_o cyc %0d got %b exp 1", c, start_o); end
      checks++;
      if (sec1_counter !== 32'((c - 1) % 10)) begin
        errors++; $display("FAIL run_counter cyc %0d got %0d exp %0d", c, sec1_counter, (c - 1) % 10);
      end
      checks++;
      if (sec1 !== ((c % 10) == 0)) begin
        errors++; $display("FAIL run_sec1 cyc %0d got %b exp %b", c, sec1, ((c % 10) == 0));
      end
      if (sec1 === 1'b1) n_sec++;
      tick();
    end
    checks++;
    if (n_sec != 3) begin errors++; $display("FAIL run_sec1_count got %0d exp 3", n_sec); end
  endtask

  task automatic test_hold_start();
    do_reset();
    start_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if (start_o !== 1'b1) begin errors++; $display("FAIL hold_start_o cyc %0d got %b exp 1", c, start_o); end
    end
    start_i = 1'b0;
    tick();
    checks++;
    if (start_o !== 1'b1) begin errors++; $display("FAIL hold_release_start_o got %b exp 1", start_o); end
  endtask

  task automatic test_pause();
    do_reset();
    pulse_start();
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (sec1_counter !== 32'd4) begin errors++; $display("FAIL pause_pre_counter got %0d exp 4", sec1_counter); end
    pulse_start();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (start_o !== 1'b0) begin errors++; $display("FAIL pause_start_o got %b exp 0", start_o); end
      checks++;
      if (sec1_counter !== 32'd5) begin errors++; $display("FAIL pause_counter got %0d exp 5", sec1_counter); end
      checks++;
      if (sec1 !== 1'b0) begin errors++; $display("FAIL pause_sec1 got %b exp 0", sec1); end
      tick();
    end
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (start_o !== 1'b1) begin errors++; $display("FAIL resume_start_o k %0d got %b exp 1", k, start_o); end
      checks++;
      if (sec1 !== (k == 5)) begin errors++; $display("FAIL resume_sec1 k %0d got %b exp %b", k, sec1, (k == 5)); end
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start();
    tick();
    tick();
    start_i  = 1'b1;
    tim_zero = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL to_timeout got %b exp 1", timeout); end
    checks++;
    if (start_o !== 1'b0) begin errors++; $display("FAIL to_start_o got %b exp 0", start_o); end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (sec1_counter !== 32'((3 + k) % 10)) begin
        errors++; $display("FAIL to_counter k %0d got %0d exp %0d", k, sec1_counter, (3 + k) % 10);
      end
      checks++;
      if (sec1 !== 1'b0) begin errors++; $display("FAIL to_sec1 k %0d got %b exp 0", k, sec1); end
      checks++;
      if (timeout !== 1'b1) begin errors++; $display("FAIL to_hold k %0d got %b exp 1", k, timeout); end
      tick();
    end
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (timeout !== 1'b0 || start_o !== 1'b0) begin
        errors++; $display("FAIL to_idle k %0d got timeout %b start_o %b exp 0 0", k, timeout, start_o);
      end
      checks++;
      if (sec1_counter !== 32'd0) begin errors++; $display("FAIL to_idle_counter got %0d exp 0", sec1_counter); end
      tick();
    end
    tim_zero = 1'b0;
  endtask

  task automatic test_tick_at_timeout();
    do_reset();
    pulse_start();
    for (int c = 0; c < 9; c++) tick();
    tim_zero = 1'b1;
    checks++;
    if (sec1 !== 1'b1) begin errors++; $display("FAIL tz_sec1 got %b exp 1", sec1); end
    tick();
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL tz_timeout got %b exp 1", timeout); end
    checks++;
    if (sec1_counter !== 32'd0 || sec1 !== 1'b0) begin
      errors++; $display("FAIL tz_after got counter %0d sec1 %b exp 0 0", sec1_counter, sec1);
    end
    tim_zero = 1'b0;
  endtask

  task automatic test_scan();
    do_reset();
    checks++;
    if (oe_digit !== 2'd0) begin errors++; $display("FAIL scan n 0 got %0d exp 0", oe_digit); end
    for (int n = 1; n <= 13; n++) begin
      tick();
      checks++;
      if (oe_digit !== 2'((n / 4) % 3)) begin
        errors++; $display("FAIL scan n %0d got %0d exp %0d", n, oe_digit, (n / 4) % 3);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_start();
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (start_o !== 1'b1 || oe_digit !== 2'd1 || sec1_counter !== 32'd5) begin
      errors++; $display("FAIL arst_pre got start_o %b digit %0d counter %0d exp 1 1 5", start_o, oe_digit, sec1_counter);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (start_o !== 1'b0) begin errors++; $display("FAIL arst_start_o got %b exp 0", start_o); end
    checks++;
    if (sec1_counter !== 32'd0) begin errors++; $display("FAIL arst_counter got %0d exp 0", sec1_counter); end
    checks++;
    if (oe_digit !== 2'd0) begin errors++; $display("FAIL arst_oe_digit got %0d exp 0", oe_digit); end
    checks++;
    if (timeout !== 1'b0 || sec1 !== 1'b0) begin
      errors++; $display("FAIL arst_misc got timeout %b sec1 %b exp 0 0", timeout, sec1);
    end
    #1;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (start_o !== 1'b0) begin errors++; $display("FAIL arst_idle got %b exp 0", start_o); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start_i  = 1'b0;
    tim_zero = 1'b0;
    test_reset();
    test_run_ticks();
    test_hold_start();
    test_pause();
    test_timeout();
    test_tick_at_timeout();
    test_scan();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
